trayectoria_checker: RTL

- Consumes the hop-by-hop trajectory that a mesh route generator produces, on the 6x6 coordinate grid:
  - rows/columns 0 and 5 are terminal ports;
  - rows/columns 1..4 are routers.
- Checks that every hop is legal and that the path ends at the declared destination.
- Re-encodes the final coordinate into a 4-bit terminal ID.
- Sits in the verification environment between the DUT trajectory monitor and the scoreboard.

---
 rtl/trayectoria_pkg.sv | 53 +++++
 rtl/trayectoria_checker_terminal_id_encoder.sv | 36 +++
 rtl/trayectoria_checker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/trayectoria_pkg.sv
// Shared types and constants for the mesh trajectory checker.
// Optional hop-order check is enabled by defining TRAYECTORIA_ORDER_CHECK_EN.
package trayectoria_pkg;

  localparam int unsigned FILAS    = 4;
  localparam int unsigned COLUMNAS = 4;
  localparam int unsigned COORD_W  = 3;
  localparam int unsigned MAX_HOPS = 16;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned ERR_W    = 3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2
  } state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE  = 3'd0,
    ERR_ADJ   = 3'd1,
    ERR_RANGE = 3'd2,
    ERR_OVF   = 3'd3,
    ERR_END   = 3'd4,
    ERR_ORDER = 3'd5
  } err_e;

  // Border coordinates of the grid (terminal ports live on these lines)
  localparam coord_t FILA_MIN = COORD_W'(0);
  localparam coord_t FILA_MAX = COORD_W'(FILAS + 1);
  localparam coord_t COL_MIN  = COORD_W'(0);
  localparam coord_t COL_MAX  = COORD_W'(COLUMNAS + 1);

  localparam logic [ID_W-1:0] ID_INVALID = 4'hF;

  // True when a and b differ by exactly one (computed one bit wider to avoid wrap)
  function automatic logic one_apart(input coord_t a, input coord_t b);
    logic [COORD_W:0] ax;
    logic [COORD_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return (ax == bx + (COORD_W+1)'(1)) || (bx == ax + (COORD_W+1)'(1));
  endfunction

  // Manhattan distance of exactly one between two grid points
  function automatic logic is_adjacent(input coord_t af, input coord_t ac,
                                       input coord_t bf, input coord_t bc);
    return ((af == bf) && one_apart(ac, bc)) || ((ac == bc) && one_apart(af, bf));
  endfunction

endpackage

// File: rtl/trayectoria_checker_terminal_id_encoder.sv
// Combinational grid coordinate to 4-bit terminal ID; 4'hF for non-border points.
module terminal_id_encoder
  import trayectoria_pkg::*;
(
  input  coord_t          fila,
  input  coord_t          col,
  output logic [ID_W-1:0] id_c
);

  localparam int unsigned IDX_W = ID_W;

  logic [IDX_W-1:0] fila_idx;
  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] lin;
  logic             on_border;
  logic             in_range;

  // Border-clamped row/column indices combined row-major, modulo 16
  always_comb begin
    in_range  = (fila <= FILA_MAX) && (col <= COL_MAX);
    on_border = (fila == FILA_MIN) || (fila == FILA_MAX) ||
                (col == COL_MIN) || (col == COL_MAX);

    if (fila == FILA_MIN)      fila_idx = '0;
    else if (fila >= FILA_MAX) fila_idx = IDX_W'(FILAS - 1);
    else                       fila_idx = IDX_W'(fila) - IDX_W'(1);

    if (col == COL_MIN)        col_idx = '0;
    else if (col >= COL_MAX)   col_idx = IDX_W'(COLUMNAS - 1);
    else                       col_idx = IDX_W'(col) - IDX_W'(1);

    lin  = fila_idx * IDX_W'(COLUMNAS) + col_idx;
    id_c = (on_border && in_range) ? lin : ID_INVALID;
  end

endmodule

// File: rtl/trayectoria_checker.sv
// Hop-by-hop mesh trajectory checker: legality, endpoint match, terminal ID.
// Define TRAYECTORIA_ORDER_CHECK_EN to add the row/column order check (err 5).
module trayectoria_checker
  import trayectoria_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] src_fila,
  input  logic [COORD_W-1:0] src_col,
  input  logic [COORD_W-1:0] dst_fila,
  input  logic [COORD_W-1:0] dst_col,
  input  logic               modo,
  input  logic               hop_valid,
  input  logic [COORD_W-1:0] hop_fila,
  input  logic [COORD_W-1:0] hop_col,
  input  logic               hop_last,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_code,
  output logic [CNT_W-1:0]   hop_count,
  output logic [ID_W-1:0]    dst_id,
  output logic               busy
);

  state_e           state_q, state_d;
  coord_t           cur_fila_q, cur_fila_d;
  coord_t           cur_col_q, cur_col_d;
  coord_t           dst_fila_q, dst_fila_d;
  coord_t           dst_col_q, dst_col_d;
  err_e             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_code_q, err_code_d;
  logic [ID_W-1:0]  dst_id_q, dst_id_d;
  logic             busy_q, busy_d;

  err_e             hop_err_c;
  err_e             err_acc_c;
  logic             order_bad_c;
  logic [ID_W-1:0]  enc_id_c;

`ifdef TRAYECTORIA_ORDER_CHECK_EN
  logic             modo_q, modo_d;
  logic             flag_q, flag_d;
  logic             interior_c;
  logic             row_move_c;
`else
  logic             unused_modo;
  assign unused_modo = modo;
`endif

  terminal_id_encoder u_enc (
    .fila (hop_fila),
    .col  (hop_col),
    .id_c (enc_id_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start always (re)loads a path, hop_last ends it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = TRACK;
      TRACK: begin
        if (start)                       state_d = TRACK;
        else if (hop_valid && hop_last)  state_d = REPORT;
      end
      REPORT:  state_d = start ? TRACK : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hop checks and next values of path context and registered outputs
  always_comb begin
    cur_fila_d  = cur_fila_q;
    cur_col_d   = cur_col_q;
    dst_fila_d  = dst_fila_q;
    dst_col_d   = dst_col_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    dst_id_d    = dst_id_q;
    done_d      = 1'b0;
    pass_d      = 1'b0;
    err_code_d  = '0;
    busy_d      = (state_d == TRACK);
    hop_err_c   = ERR_NONE;
    err_acc_c   = err_q;
    order_bad_c = 1'b0;
`ifdef TRAYECTORIA_ORDER_CHECK_EN
    modo_d      = modo_q;
    flag_d      = flag_q;
    interior_c  = 1'b0;
    row_move_c  = 1'b0;
`endif

    if (start) begin
      cur_fila_d = src_fila;
      cur_col_d  = src_col;
      dst_fila_d = dst_fila;
      dst_col_d  = dst_col;
      err_d      = ERR_NONE;
      cnt_d      = '0;
      dst_id_d   = '0;
`ifdef TRAYECTORIA_ORDER_CHECK_EN
      modo_d     = modo;
      flag_d     = 1'b0;
`endif
    end else if ((state_q == TRACK) && hop_valid) begin
`ifdef TRAYECTORIA_ORDER_CHECK_EN
      // Interior hops only; flag records that the second axis has started
      interior_c = (cnt_q != '0) && !hop_last;
      row_move_c = (hop_fila != cur_fila_q);
      if (interior_c) begin
        if (modo_q == row_move_c) flag_d = 1'b1;
        else if (flag_q)          order_bad_c = 1'b1;
      end
`endif
      if ((hop_fila > FILA_MAX) || (hop_col > COL_MAX))
        hop_err_c = ERR_RANGE;
      else if (!is_adjacent(hop_fila, hop_col, cur_fila_q, cur_col_q))
        hop_err_c = ERR_ADJ;
      else if (cnt_q == CNT_W'(MAX_HOPS))
        hop_err_c = ERR_OVF;
      else if (order_bad_c)
        hop_err_c = ERR_ORDER;

      if (err_q == ERR_NONE) err_acc_c = hop_err_c;
      if (hop_last && (err_acc_c == ERR_NONE) &&
          ((hop_fila != dst_fila_q) || (hop_col != dst_col_q)))
        err_acc_c = ERR_END;

      err_d     = err_acc_c;
      cur_fila_d = hop_fila;
      cur_col_d  = hop_col;
      if (cnt_q != CNT_W'(MAX_HOPS)) cnt_d = cnt_q + CNT_W'(1);

      if (hop_last) begin
        done_d     = 1'b1;
        pass_d     = (err_acc_c == ERR_NONE);
        err_code_d = err_acc_c;
        dst_id_d   = enc_id_c;
      end
    end
  end

  // Path context and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_fila_q <= '0;
      cur_col_q  <= '0;
      dst_fila_q <= '0;
      dst_col_q  <= '0;
      err_q      <= ERR_NONE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_code_q <= '0;
      dst_id_q   <= '0;
      busy_q     <= 1'b0;
`ifdef TRAYECTORIA_ORDER_CHECK_EN
      modo_q     <= 1'b0;
      flag_q     <= 1'b0;
`endif
    end else begin
      cur_fila_q <= cur_fila_d;
      cur_col_q  <= cur_col_d;
      dst_fila_q <= dst_fila_d;
      dst_col_q  <= dst_col_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_code_q <= err_code_d;
      dst_id_q   <= dst_id_d;
      busy_q     <= busy_d;
`ifdef TRAYECTORIA_ORDER_CHECK_EN
      modo_q     <= modo_d;
      flag_q     <= flag_d;
`endif
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign err_code  = err_code_q;
  assign hop_count = cnt_q;
  assign dst_id    = dst_id_q;
  assign busy      = busy_q;

endmodule
